// File: rtl/multiplicador_booth_uc_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: mux select codes,
// controller states and the Booth digit decoder.
package multiplicador_booth_uc_pkg;

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_POS1   = 3'b001;
  localparam logic [2:0] OP_POS2   = 3'b010;
  localparam logic [2:0] OP_NEG1   = 3'b011;
  localparam logic [2:0] OP_NEG2   = 3'b100;
  localparam logic [2:0] OP_ZERO_F = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

  // Digit is (q[2i+1], q[2i], q[2i-1]).
  function automatic logic [2:0] booth_sel(input logic [2:0] digit);
    logic [2:0] sel;
    case (digit)
      3'b001, 3'b010: sel = OP_POS1;
      3'b011:         sel = OP_POS2;
      3'b100:         sel = OP_NEG2;
      3'b101, 3'b110: sel = OP_NEG1;
      default:        sel = OP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mux_six_to_one.sv
// 6:1 partial-product multiplexer; codes above 101 fall back to zero.
module mux_six_to_one #(
  parameter int unsigned Width = 16
) (
  input  logic [2:0]       sel,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] c,
  input  logic [Width-1:0] d,
  input  logic [Width-1:0] e,
  input  logic [Width-1:0] f,
  output logic [Width-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      3'b000:  y = a;
      3'b001:  y = b;
      3'b010:  y = c;
      3'b011:  y = d;
      3'b100:  y = e;
      3'b101:  y = f;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multiplicador_booth_uc.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per CALC cycle,
// accumulating the selected partial product into produto.
module multiplicador_booth_uc
  import multiplicador_booth_uc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [N-1:0]     multiplicando,
  input  logic [N-1:0]     multiplicador,
  output logic [2*N-1:0]   produto,
  output logic [2:0]       sel_op,
  output logic             ocupado,
  output logic             pronto
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned IW = $clog2(N / 2);
  localparam logic [IW-1:0] ILast = IW'(N / 2 - 1);

  state_e         state_q;
  logic [W-1:0]   m_q;
  logic [N:0]     qx_q;
  logic [IW-1:0]  i_q;
  logic [W-1:0]   produto_q;

  logic [W-1:0]   m_x2;
  logic [W-1:0]   m_neg;
  logic [W-1:0]   m_neg_x2;
  logic [W-1:0]   pp;
  logic [W-1:0]   pp_shifted;

  assign m_x2     = m_q << 1;
  assign m_neg    = W'(0) - m_q;
  assign m_neg_x2 = W'(0) - m_x2;

  assign sel_op = (state_q == StCalc) ? booth_sel(qx_q[2:0]) : OP_ZERO;

  mux_six_to_one #(
    .Width (W)
  ) u_mux (
    .sel (sel_op),
    .a   ('0),
    .b   (m_q),
    .c   (m_x2),
    .d   (m_neg),
    .e   (m_neg_x2),
    .f   ('0),
    .y   (pp)
  );

  // Digit i carries weight 4^i.
  assign pp_shifted = pp << {i_q, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      m_q       <= '0;
      qx_q      <= '0;
      i_q       <= '0;
      produto_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (iniciar) begin
            m_q       <= {{N{multiplicando[N-1]}}, multiplicando};
            qx_q      <= {multiplicador, 1'b0};
            i_q       <= '0;
            produto_q <= '0;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          produto_q <= produto_q + pp_shifted;
          qx_q      <= $signed(qx_q) >>> 2;
          i_q       <= i_q + 1'b1;
          if (i_q == ILast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign produto = produto_q;
  assign ocupado = (state_q == StCalc);
  assign pronto  = (state_q == StDone);

endmodule

// File: tb/tb_multiplicador_booth_uc.sv
// Directed bench for the Booth multiplier controller with hand-computed
// expectations, sampled on the falling clock edge.
module tb_multiplicador_booth_uc;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic [15:0] produto;
  logic [2:0]  sel_op;
  logic        ocupado;
  logic        pronto;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_busy;
  int cnt_done;

  multiplicador_booth_uc #(
    .N (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .produto       (produto),
    .sel_op        (sel_op),
    .ocupado       (ocupado),
    .pronto        (pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge of the first CALC cycle.
  task automatic start(input logic [7:0] m, input logic [7:0] q);
    multiplicando = m;
    multiplicador = q;
    iniciar       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
    start(m, q);
    repeat (4) @(negedge clock);
    chk({tag, "_pronto"}, {15'b0, pronto}, 16'd1);
    chk({tag, "_produto"}, produto, exp);
    @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    iniciar       = 1'b0;
    multiplicando = '0;
    multiplicador = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_produto", produto, 16'h0000);
    chk("rst_sel_op", {13'b0, sel_op}, 16'd0);
    chk("rst_ocupado", {15'b0, ocupado}, 16'd0);
    chk("rst_pronto", {15'b0, pronto}, 16'd0);
    reset = 1'b0;
    @(negedge clock);

    // 7 * 6: digits of Q=6 give -2M, +2M, 0, 0
    start(8'd7, 8'd6);
    chk("m7q6_sel0", {13'b0, sel_op}, 16'b100);
    chk("m7q6_busy0", {15'b0, ocupado}, 16'd1);
    @(negedge clock);
    chk("m7q6_sel1", {13'b0, sel_op}, 16'b010);
    @(negedge clock);
    chk("m7q6_sel2", {13'b0, sel_op}, 16'b000);
    @(negedge clock);
    chk("m7q6_sel3", {13'b0, sel_op}, 16'b000);
    chk("m7q6_nopronto3", {15'b0, pronto}, 16'd0);
    @(negedge clock);
    chk("m7q6_pronto", {15'b0, pronto}, 16'd1);
    chk("m7q6_busy_done", {15'b0, ocupado}, 16'd0);
    chk("m7q6_sel_done", {13'b0, sel_op}, 16'd0);
    chk("m7q6_produto", produto, 16'h002A);
    @(negedge clock);
    chk("m7q6_pronto_pulse", {15'b0, pronto}, 16'd0);
    repeat (2) @(negedge clock);
    chk("idle_hold_produto", produto, 16'h002A);

    // Signed corners
    run_op("m128q128", 8'h80, 8'h80, 16'h4000);
    run_op("mneg5q3", 8'hFB, 8'h03, 16'hFFF1);
    run_op("m127qneg128", 8'h7F, 8'h80, 16'hC080);

    // iniciar held through CALC and DONE: exactly one operation
    multiplicando = 8'hFB;
    multiplicador = 8'h03;
    iniciar       = 1'b1;
    cnt_busy      = 0;
    cnt_done      = 0;
    @(posedge clock);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (ocupado) cnt_busy++;
      if (pronto) begin
        cnt_done++;
        iniciar = 1'b0;
      end
    end
    chk("hold_busy_cycles", 16'(cnt_busy), 16'd4);
    chk("hold_pronto_pulses", 16'(cnt_done), 16'd1);
    chk("hold_produto", produto, 16'hFFF1);
    chk("hold_idle", {15'b0, ocupado}, 16'd0);

    // Operand changes during CALC are ignored
    start(8'd3, 8'd5);
    multiplicando = 8'h7F;
    multiplicador = 8'h7F;
    repeat (4) @(negedge clock);
    chk("late_op_pronto", {15'b0, pronto}, 16'd1);
    chk("late_op_produto", produto, 16'd15);
    @(negedge clock);

    // Reset in the second CALC cycle aborts
    start(8'd7, 8'd6);
    @(negedge clock);
    chk("abort_busy_pre", {15'b0, ocupado}, 16'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", {15'b0, ocupado}, 16'd0);
    chk("abort_produto", produto, 16'h0000);
    cnt_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (pronto) cnt_done++;
    end
    chk("abort_no_pronto", 16'(cnt_done), 16'd0);
    run_op("m2qneg3", 8'd2, 8'hFD, 16'hFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
